regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file for the processor datapath, replacing the fixed 8-entry file. Provides two registered read ports with write-to-read bypass, one write port, and a per-register busy scoreboard so the control unit can stall on operands whose multi-cycle load has not yet returned. Optionally hardwires register 0 to zero.

## Interface

- NUM_REGS, 8: number of registers, at least 2, power of two.
- DATA_BITS, 8: register width.
- ADDR_BITS, $clog2(NUM_REGS): address width. Derived; never overridden.
- ZERO_REG, 0: 1 makes register 0 read as zero and never be written or reserved.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd0_addr  in  ADDR_BITS  read port 0 address.
- rd0_enable  in  1  capture read port 0 this cycle.
- rd0_data  out  DATA_BITS  registered read data, port 0.
- rd0_busy  out  1  registered busy flag of the register read on port 0.
- rd1_addr, rd1_enable, rd1_data, rd1_busy: same as port 0, port 1.
- wr_addr  in  ADDR_BITS  write address.
- wr_enable  in  1  write wr_data this cycle.
- wr_data  in  DATA_BITS  write data.
- resv_addr  in  ADDR_BITS  register to mark pending.
- resv_enable  in  1  set the busy bit of resv_addr this cycle.
- busy_mask  out  NUM_REGS  registered scoreboard; bit i = register i pending.

## Operation

- State: NUM_REGS x DATA_BITS storage array plus NUM_REGS busy bits.
- Write: wr_enable=1 loads wr_data into wr_addr and clears busy[wr_addr].
- Reserve: resv_enable=1 sets busy[resv_addr].
- Write and reserve to the same address in the same cycle: data is written; busy ends 1, because a new pending load was issued.
- Write and reserve to different addresses: both take effect independently.
- Read, rdN_enable=1: rdN_data and rdN_busy load the next-state value and busy bit of rdN_addr.
  - Next-state includes the same cycle's write, so the write is bypassed.
  - Next-state includes the same cycle's reserve.
- Read, rdN_enable=0: rdN_data and rdN_busy hold their previous values.
- Both ports may read the same address in the same cycle; both return identical results.
- ZERO_REG=1:
  - Writes and reserves to address 0 are ignored.
  - busy[0] is constantly 0.
  - Reads of address 0 return 0, not busy.
- ZERO_REG=0: register 0 is an ordinary register.
- There is no read of un-reset or uninitialised state; every register starts at 0.

## Timing

- Reset, which overrides all other inputs that cycle:
  - Every register is set to 0.
  - Every busy bit is cleared.
  - rd0_data, rd1_data, rd0_busy and rd1_busy are set to 0.
  - busy_mask is set to 0.
- Read latency is 1 cycle.
  - Address and enable are sampled at edge N.
  - Data and busy are valid after edge N and stay stable until the next enabled read.
- Write latency is 1 cycle. A write sampled at edge N is visible in storage after edge N.
- A read sampled at that same edge N already returns the written value, through the bypass.
- busy_mask reflects all writes and reserves sampled at edge N, immediately after edge N.
- No handshake exists; every enabled operation completes in the cycle it is presented.
- The control unit stalls while rdN_busy=1 and re-issues the read on the following cycles.

## Test plan

- Reset: write 0x5A to all registers, then assert reset for 1 cycle. Read all addresses on both ports -> every rd_data = 0x00 and busy_mask = 0.
- Write/read, with NUM_REGS=16 and DATA_BITS=16:
  - Write r(i) = 0x1000+i for all i.
  - Read port 0 = i and port 1 = 15-i -> values appear 1 cycle after each read.
  - rd data holds while enable is low.
- Bypass and collision:
  - r3 holds 0x11. Write r3 = 0x22 while reading r3 on both ports in the same cycle -> both ports return 0x22.
  - Next cycle, with enable low -> outputs hold 0x22.
- Scoreboard:
  - Reserve r5 -> busy_mask[5] = 1. Reading r5 returns rd_busy = 1.
  - Write r5 = 0x77 -> busy clears. A same-cycle read returns 0x77 with busy 0.
  - Write and reserve r6 in the same cycle -> data written, busy_mask[6] = 1.
- ZERO_REG=1:
  - Write r0 = 0xFF and reserve r0 -> reads of r0 return 0x00 with busy 0, and busy_mask[0] = 0.
  - r1 behaves normally.
- Reset mid-operation: reserve r2, r4 and write r7 = 0x33 in the same cycle as reset -> all state is 0 afterwards and no busy bits are set.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two registered read ports (write/reserve bypass),
// one write port, and a per-register busy scoreboard for pending multi-cycle loads.
module regfile_scoreboard #(
  parameter int NUM_REGS  = 8,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = $clog2(NUM_REGS),
  parameter int ZERO_REG  = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ADDR_BITS-1:0] rd0_addr_i,
  input  logic                 rd0_enable_i,
  output logic [DATA_BITS-1:0] rd0_data_o,
  output logic                 rd0_busy_o,
  input  logic [ADDR_BITS-1:0] rd1_addr_i,
  input  logic                 rd1_enable_i,
  output logic [DATA_BITS-1:0] rd1_data_o,
  output logic                 rd1_busy_o,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic                 wr_enable_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic [ADDR_BITS-1:0] resv_addr_i,
  input  logic                 resv_enable_i,
  output logic [NUM_REGS-1:0]  busy_mask_o
);

  logic [DATA_BITS-1:0] mem_q [NUM_REGS];
  logic [DATA_BITS-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [DATA_BITS-1:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
  logic                 rd0_busy_q, rd0_busy_d, rd1_busy_q, rd1_busy_d;
  logic                 wr_ok, resv_ok;

  // With a hardwired zero register, operations aimed at address 0 are dropped.
  always_comb begin
    wr_ok   = wr_enable_i;
    resv_ok = resv_enable_i;
    if ((ZERO_REG != 0) && (wr_addr_i == '0)) begin
      wr_ok = 1'b0;
    end else begin
      wr_ok = wr_enable_i;
    end
    if ((ZERO_REG != 0) && (resv_addr_i == '0)) begin
      resv_ok = 1'b0;
    end else begin
      resv_ok = resv_enable_i;
    end
  end

  // Storage and scoreboard next state; a reserve wins over a same-address write's clear.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[wr_addr_i]  = wr_data_i;
      busy_d[wr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (resv_ok) begin
      busy_d[resv_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Reads sample next state, which bypasses the same-cycle write and reserve.
  always_comb begin
    rd0_data_d = rd0_data_q;
    rd0_busy_d = rd0_busy_q;
    rd1_data_d = rd1_data_q;
    rd1_busy_d = rd1_busy_q;
    if (rd0_enable_i) begin
      rd0_data_d = mem_d[rd0_addr_i];
      rd0_busy_d = busy_d[rd0_addr_i];
    end else begin
      rd0_data_d = rd0_data_q;
      rd0_busy_d = rd0_busy_q;
    end
    if (rd1_enable_i) begin
      rd1_data_d = mem_d[rd1_addr_i];
      rd1_busy_d = busy_d[rd1_addr_i];
    end else begin
      rd1_data_d = rd1_data_q;
      rd1_busy_d = rd1_busy_q;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      rd0_data_q <= '0;
      rd0_busy_q <= 1'b0;
      rd1_data_q <= '0;
      rd1_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q     <= busy_d;
      rd0_data_q <= rd0_data_d;
      rd0_busy_q <= rd0_busy_d;
      rd1_data_q <= rd1_data_d;
      rd1_busy_q <= rd1_busy_d;
    end
  end

  assign rd0_data_o  = rd0_data_q;
  assign rd0_busy_o  = rd0_busy_q;
  assign rd1_data_o  = rd1_data_q;
  assign rd1_busy_o  = rd1_busy_q;
  assign busy_mask_o = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a 16x16 file with ordinary r0 and an 8x8 file with hardwired r0.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16 registers x 16 bits, ZERO_REG=0
  logic        a_reset, a_rd0_en, a_rd1_en, a_wr_en, a_resv_en;
  logic [3:0]  a_rd0_addr, a_rd1_addr, a_wr_addr, a_resv_addr;
  logic [15:0] a_wr_data, a_rd0_data, a_rd1_data, a_mask;
  logic        a_rd0_busy, a_rd1_busy;

  // 8 registers x 8 bits, ZERO_REG=1
  logic        z_reset, z_rd0_en, z_rd1_en, z_wr_en, z_resv_en;
  logic [2:0]  z_rd0_addr, z_rd1_addr, z_wr_addr, z_resv_addr;
  logic [7:0]  z_wr_data, z_rd0_data, z_rd1_data, z_mask;
  logic        z_rd0_busy, z_rd1_busy;

  regfile_scoreboard #(.NUM_REGS(16), .DATA_BITS(16), .ZERO_REG(0)) dut_a (
    .clk_i(clk), .reset_i(a_reset),
    .rd0_addr_i(a_rd0_addr), .rd0_enable_i(a_rd0_en), .rd0_data_o(a_rd0_data), .rd0_busy_o(a_rd0_busy),
    .rd1_addr_i(a_rd1_addr), .rd1_enable_i(a_rd1_en), .rd1_data_o(a_rd1_data), .rd1_busy_o(a_rd1_busy),
    .wr_addr_i(a_wr_addr), .wr_enable_i(a_wr_en), .wr_data_i(a_wr_data),
    .resv_addr_i(a_resv_addr), .resv_enable_i(a_resv_en), .busy_mask_o(a_mask)
  );

  regfile_scoreboard #(.NUM_REGS(8), .DATA_BITS(8), .ZERO_REG(1)) dut_z (
    .clk_i(clk), .reset_i(z_reset),
    .rd0_addr_i(z_rd0_addr), .rd0_enable_i(z_rd0_en), .rd0_data_o(z_rd0_data), .rd0_busy_o(z_rd0_busy),
    .rd1_addr_i(z_rd1_addr), .rd1_enable_i(z_rd1_en), .rd1_data_o(z_rd1_data), .rd1_busy_o(z_rd1_busy),
    .wr_addr_i(z_wr_addr), .wr_enable_i(z_wr_en), .wr_data_i(z_wr_data),
    .resv_addr_i(z_resv_addr), .resv_enable_i(z_resv_en), .busy_mask_o(z_mask)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    a_reset = 1'b0; a_rd0_en = 1'b0; a_rd1_en = 1'b0; a_wr_en = 1'b0; a_resv_en = 1'b0;
    a_rd0_addr = 4'd0; a_rd1_addr = 4'd0; a_wr_addr = 4'd0; a_resv_addr = 4'd0; a_wr_data = 16'h0000;
    z_reset = 1'b0; z_rd0_en = 1'b0; z_rd1_en = 1'b0; z_wr_en = 1'b0; z_resv_en = 1'b0;
    z_rd0_addr = 3'd0; z_rd1_addr = 3'd0; z_wr_addr = 3'd0; z_resv_addr = 3'd0; z_wr_data = 8'h00;
  endtask

  task automatic test_reset;
    idle_all();
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 16'h005A;
      a_resv_en = (i == 9); a_resv_addr = 4'd9;
      a_rd0_en = 1'b1; a_rd0_addr = 4'(i);
      tick();
    end
    idle_all();
    a_reset = 1'b1; z_reset = 1'b1;
    tick();
    idle_all();
    if (a_rd0_data !== 16'h0000 || a_rd0_busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got=%h/%b exp=0000/0", a_rd0_data, a_rd0_busy);
    end
    checks++;
    if (a_mask !== 16'h0000) begin
      errors++; $display("FAIL reset_mask got=%h exp=0000", a_mask);
    end
    checks++;
    for (int i = 0; i < 16; i++) begin
      a_rd0_en = 1'b1; a_rd0_addr = 4'(i);
      a_rd1_en = 1'b1; a_rd1_addr = 4'(i);
      tick();
      if (a_rd0_data !== 16'h0000 || a_rd1_data !== 16'h0000 || a_rd0_busy !== 1'b0 || a_rd1_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_read r%0d got=%h,%h busy=%b%b exp=0000,0000 busy=00",
                 i, a_rd0_data, a_rd1_data, a_rd0_busy, a_rd1_busy);
      end
      checks++;
    end
    idle_all();
  endtask

  task automatic test_write_read;
    idle_all();
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 16'h1000 + 16'(i);
      tick();
    end
    idle_all();
    for (int i = 0; i < 16; i++) begin
      a_rd0_en = 1'b1; a_rd0_addr = 4'(i);
      a_rd1_en = 1'b1; a_rd1_addr = 4'(15 - i);
      tick();
      if (a_rd0_data !== 16'h1000 + 16'(i)) begin
        errors++; $display("FAIL rd0_value r%0d got=%h exp=%h", i, a_rd0_data, 16'h1000 + 16'(i));
      end
      checks++;
      if (a_rd1_data !== 16'h1000 + 16'(15 - i)) begin
        errors++; $display("FAIL rd1_value r%0d got=%h exp=%h", 15 - i, a_rd1_data, 16'h1000 + 16'(15 - i));
      end
      checks++;
    end
    // last read: port0 r15, port1 r0; disable and move addresses
    a_rd0_en = 1'b0; a_rd0_addr = 4'd4;
    a_rd1_en = 1'b0; a_rd1_addr = 4'd7;
    tick();
    tick();
    if (a_rd0_data !== 16'h100F || a_rd1_data !== 16'h1000) begin
      errors++; $display("FAIL read_hold got=%h,%h exp=100f,1000", a_rd0_data, a_rd1_data);
    end
    checks++;
    idle_all();
  endtask

  task automatic test_bypass;
    idle_all();
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 16'h0011;
    tick();
    a_wr_data = 16'h0022;
    a_rd0_en = 1'b1; a_rd0_addr = 4'd3;
    a_rd1_en = 1'b1; a_rd1_addr = 4'd3;
    tick();
    if (a_rd0_data !== 16'h0022 || a_rd1_data !== 16'h0022) begin
      errors++; $display("FAIL bypass_collision got=%h,%h exp=0022,0022", a_rd0_data, a_rd1_data);
    end
    checks++;
    // storage changes again but reads are disabled
    a_rd0_en = 1'b0; a_rd1_en = 1'b0; a_wr_data = 16'h0099;
    tick();
    if (a_rd0_data !== 16'h0022 || a_rd1_data !== 16'h0022) begin
      errors++; $display("FAIL bypass_hold got=%h,%h exp=0022,0022", a_rd0_data, a_rd1_data);
    end
    checks++;
    idle_all();
    a_rd0_en = 1'b1; a_rd0_addr = 4'd3;
    tick();
    if (a_rd0_data !== 16'h0099) begin
      errors++; $display("FAIL storage_after_hold got=%h exp=0099", a_rd0_data);
    end
    checks++;
    idle_all();
  endtask

  task automatic test_scoreboard;
    idle_all();
    a_resv_en = 1'b1; a_resv_addr = 4'd5;
    a_rd1_en = 1'b1; a_rd1_addr = 4'd5;
    tick();
    if (a_mask !== 16'h0020 || a_rd1_busy !== 1'b1) begin
      errors++; $display("FAIL reserve_r5 mask=%h busy=%b exp mask=0020 busy=1", a_mask, a_rd1_busy);
    end
    checks++;
    idle_all();
    a_rd0_en = 1'b1; a_rd0_addr = 4'd5;
    tick();
    if (a_rd0_busy !== 1'b1 || a_rd0_data !== 16'h1005) begin
      errors++; $display("FAIL read_busy_r5 got=%h/%b exp=1005/1", a_rd0_data, a_rd0_busy);
    end
    checks++;
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'h0077;
    tick();
    if (a_rd0_data !== 16'h0077 || a_rd0_busy !== 1'b0 || a_mask !== 16'h0000) begin
      errors++; $display("FAIL write_clears_r5 got=%h/%b mask=%h exp=0077/0 mask=0000", a_rd0_data, a_rd0_busy, a_mask);
    end
    checks++;
    idle_all();
    a_wr_en = 1'b1; a_wr_addr = 4'd6; a_wr_data = 16'h0066;
    a_resv_en = 1'b1; a_resv_addr = 4'd6;
    a_rd1_en = 1'b1; a_rd1_addr = 4'd6;
    tick();
    if (a_rd1_data !== 16'h0066 || a_rd1_busy !== 1'b1 || a_mask !== 16'h0040) begin
      errors++; $display("FAIL write_resv_same got=%h/%b mask=%h exp=0066/1 mask=0040", a_rd1_data, a_rd1_busy, a_mask);
    end
    checks++;
    // different addresses: r6 load returns while r8 is reserved
    a_wr_addr = 4'd6; a_wr_data = 16'h0abc; a_resv_addr = 4'd8;
    a_rd0_en = 1'b1; a_rd0_addr = 4'd8;
    tick();
    if (a_mask !== 16'h0100 || a_rd1_data !== 16'h0abc || a_rd1_busy !== 1'b0 || a_rd0_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_resv_diff mask=%h rd1=%h/%b rd0busy=%b exp mask=0100 rd1=0abc/0 rd0busy=1",
               a_mask, a_rd1_data, a_rd1_busy, a_rd0_busy);
    end
    checks++;
    idle_all();
  endtask

  task automatic test_zero_reg;
    idle_all();
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 8'hFF;
    z_resv_en = 1'b1; z_resv_addr = 3'd0;
    z_rd0_en = 1'b1; z_rd0_addr = 3'd0;
    z_rd1_en = 1'b1; z_rd1_addr = 3'd0;
    tick();
    if (z_rd0_data !== 8'h00 || z_rd1_data !== 8'h00 || z_rd0_busy !== 1'b0 || z_rd1_busy !== 1'b0 || z_mask !== 8'h00) begin
      errors++;
      $display("FAIL zero_r0_bypass got=%h,%h busy=%b%b mask=%h exp=00,00 busy=00 mask=00",
               z_rd0_data, z_rd1_data, z_rd0_busy, z_rd1_busy, z_mask);
    end
    checks++;
    idle_all();
    z_rd0_en = 1'b1; z_rd0_addr = 3'd0;
    tick();
    if (z_rd0_data !== 8'h00 || z_rd0_busy !== 1'b0) begin
      errors++; $display("FAIL zero_r0_stored got=%h/%b exp=00/0", z_rd0_data, z_rd0_busy);
    end
    checks++;
    idle_all();
    z_wr_en = 1'b1; z_wr_addr = 3'd1; z_wr_data = 8'hAB;
    z_rd1_en = 1'b1; z_rd1_addr = 3'd1;
    tick();
    if (z_rd1_data !== 8'hAB || z_rd1_busy !== 1'b0) begin
      errors++; $display("FAIL zero_r1_write got=%h/%b exp=ab/0", z_rd1_data, z_rd1_busy);
    end
    checks++;
    idle_all();
    z_resv_en = 1'b1; z_resv_addr = 3'd1;
    z_rd0_en = 1'b1; z_rd0_addr = 3'd1;
    tick();
    if (z_mask !== 8'h02 || z_rd0_busy !== 1'b1 || z_rd0_data !== 8'hAB) begin
      errors++; $display("FAIL zero_r1_reserve mask=%h rd0=%h/%b exp mask=02 rd0=ab/1", z_mask, z_rd0_data, z_rd0_busy);
    end
    checks++;
    idle_all();
  endtask

  task automatic test_reset_mid;
    idle_all();
    a_resv_en = 1'b1; a_resv_addr = 4'd2;
    tick();
    a_reset = 1'b1;
    a_resv_addr = 4'd4;
    a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 16'h0033;
    a_rd0_en = 1'b1; a_rd0_addr = 4'd7;
    a_rd1_en = 1'b1; a_rd1_addr = 4'd4;
    tick();
    if (a_mask !== 16'h0000 || a_rd0_data !== 16'h0000 || a_rd1_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid mask=%h rd0=%h rd1busy=%b exp mask=0000 rd0=0000 rd1busy=0", a_mask, a_rd0_data, a_rd1_busy);
    end
    checks++;
    idle_all();
    a_rd0_en = 1'b1; a_rd0_addr = 4'd7;
    a_rd1_en = 1'b1; a_rd1_addr = 4'd2;
    tick();
    if (a_rd0_data !== 16'h0000 || a_rd0_busy !== 1'b0 || a_rd1_busy !== 1'b0 || a_mask !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_after r7=%h/%b r2busy=%b mask=%h exp r7=0000/0 r2busy=0 mask=0000",
               a_rd0_data, a_rd0_busy, a_rd1_busy, a_mask);
    end
    checks++;
    idle_all();
  endtask

  initial begin
    idle_all();
    a_reset = 1'b1; z_reset = 1'b1;
    tick();
    tick();
    idle_all();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
